// File: rtl/counter_checker.sv
// counter_checker: receive-side monitor for an up/down counter.
// Locks onto the observed count sequence and flags any step that is not
// exactly +1/-1 (mod 2^WIDTH) in the direction applied with the previous
// sample. Exposes lock status, a one-cycle error pulse and a saturating
// error count.
// Optional build macro COUNTER_CHECKER_STALL_EN: when defined, a repeated
// value (hold) is also accepted as a legal step in SYNC and LOCK.
module counter_checker #(
    parameter int WIDTH    = 8,
    parameter int SYNC_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] c_in,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [3:0]       SYNC_TGT = 4'(SYNC_CNT);

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   prev_c_q,   prev_c_d;
    logic               prev_dir_q, prev_dir_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic               err_q,      err_d;
    logic [ERR_W-1:0]   err_cnt_q,  err_cnt_d;
    logic [WIDTH-1:0]   expected_q, expected_d;

    logic [WIDTH-1:0]   pred;
    logic               match;
    logic               hold;

    // One counter step in the given direction, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic up);
        return up ? (v + ONE) : (v - ONE);
    endfunction

    // Error count increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : (v + ERR_ONE);
    endfunction

    // The step is judged against the direction sampled with the previous value,
    // so a direction change never looks like an error.
    assign pred  = step(prev_c_q, prev_dir_q);
    assign match = (c_in == pred);
`ifdef COUNTER_CHECKER_STALL_EN
    assign hold  = (c_in == prev_c_q);
`else
    assign hold  = 1'b0;
`endif

    // Next-state and datapath: everything holds unless en qualifies the sample.
    always_comb begin
        state_d    = state_q;
        prev_c_d   = prev_c_q;
        prev_dir_d = prev_dir_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        expected_d = expected_q;

        if (en) begin
            // A mismatching sample also becomes the new reference so the
            // checker resynchronises from it.
            prev_c_d   = c_in;
            prev_dir_d = dir;
            expected_d = step(c_in, dir);

            case (state_q)
                IDLE: begin
                    good_cnt_d = 4'd0;
                    state_d    = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if ((good_cnt_q + 4'd1) == SYNC_TGT) begin
                            state_d = LOCK;
                        end
                    end else if (!hold) begin
                        good_cnt_d = 4'd0;
                    end
                end
                LOCK: begin
                    if (!(match || hold)) begin
                        err_d      = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        good_cnt_d = 4'd0;
                        state_d    = SYNC;
                    end
                end
                default: begin
                    good_cnt_d = 4'd0;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_c_q   <= '0;
            prev_dir_q <= 1'b0;
            good_cnt_q <= 4'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_c_q   <= prev_c_d;
            prev_dir_q <= prev_dir_d;
            good_cnt_q <= good_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            expected_q <= expected_d;
        end
    end

    assign locked   = (state_q == LOCK);
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign expected = expected_q;

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side monitor for the up/down counter.
- Samples the counter's value and direction each qualified cycle, then locks onto the sequence.
- Flags any step that is not exactly +1/-1 (mod 2^WIDTH) in the direction the counter was commanded.
- Sits beside the counter in benches and on-chip as a self-check; exposes lock status, an error pulse and a saturating error count.

Parameters:
- WIDTH, 8, counter width; arithmetic modulo 2^WIDTH.
- SYNC_CNT, 2, number of consecutive good steps required in SYNC before LOCK; legal range 1..15.
- ERR_W, 16, width of error counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample qualifier; c_in/dir are ignored when low.
- dir  input  1  counter direction applied at this edge: 1 = increment (+), 0 = decrement (-).
- c_in  input  WIDTH  observed counter value.
- locked  output  1  high while in LOCK.
- err  output  1  one-cycle pulse on a mismatch detected in LOCK.
- err_cnt  output  ERR_W  saturating count of err pulses.
- expected  output  WIDTH  value the checker predicts for the next qualified sample.

Behaviour:
- Reset (async assert, sync-safe release) forces:
  - state = IDLE;
  - locked = 0, err = 0, err_cnt = 0, expected = 0;
  - prev_c = 0, prev_dir = 0, good_cnt = 0.
- Prediction, computed combinationally:
  - pred = prev_c + 1 if prev_dir = 1, else prev_c - 1.
  - Truncated to WIDTH bits: 0xFF+1 -> 0x00, 0x00-1 -> 0xFF at WIDTH = 8.
- `expected` is the registered pred; it is updated on every en cycle.
- Every en cycle: prev_c <= c_in, prev_dir <= dir.
- en = 0 cycles: all state holds and err = 0.
- States:
  - IDLE: on en, capture sample, good_cnt <= 0, -> SYNC. No comparison is made.
  - SYNC: on en, if c_in == pred then good_cnt++; if the new good_cnt == SYNC_CNT -> LOCK. Else good_cnt <= 0 and stay in SYNC. No err is raised in SYNC.
  - LOCK: on en, if c_in == pred, stay in LOCK. Else:
    - err <= 1 for one cycle;
    - err_cnt <= err_cnt + 1, saturating at all-ones;
    - good_cnt <= 0, -> SYNC.
    - The mismatching sample becomes the new prev_c, so the checker resynchronises from it.
- Latency: err and locked are registered; both assert on the edge that consumes the deciding sample, i.e. one cycle after c_in is presented.
- Direction change: the step is checked against the dir sampled with the previous value.
  - Sample n is checked using dir from sample n-1.
  - A dir flip therefore never causes a false error.
- Reset mid-operation: immediate return to IDLE with outputs cleared, including err_cnt; no err is emitted for the reset itself.
- Back-to-back mismatches: the first (in LOCK) gives err; later ones land in SYNC and only clear good_cnt.

Optional Feature:
- Macro: COUNTER_CHECKER_STALL_EN.
- Defined: c_in == prev_c (hold) is also a legal step in SYNC and LOCK.
  - A hold leaves good_cnt unchanged in SYNC and raises no err in LOCK.
  - Supports counters with clock enables.
- Undefined: a hold is a mismatch like any other value.

Test Plan:
- Reset then up-count: assert reset, release, en = 1, dir = 1, c_in = 0x00, 0x01, 0x02, 0x03.
  - locked rises on the edge after 0x02 is sampled (SYNC_CNT = 2).
  - err stays 0; expected = 0x04 after 0x03.
- Wrap: locked, dir = 1, c_in 0xFE, 0xFF, 0x00 -> no err. Then dir = 0, c_in 0x00, 0xFF -> no err; expected = 0xFE.
- Direction flip mid-stream: locked at 0x10 with dir = 1, next sample 0x11 presented with dir = 0, then 0x10 -> no err, locked stays 1.
- Fault injection: locked, expected 0x21, drive c_in = 0x25.
  - err pulses exactly one cycle; err_cnt 0 -> 1; locked drops.
  - Then 0x26, 0x27 -> locked re-asserts.
- Saturation and reset: force ERR_W = 2, inject 5 faults -> err_cnt holds at 3. Assert reset mid-stream -> locked = 0, err_cnt = 0, expected = 0 immediately, without waiting for a clock edge.
- Stall: locked, c_in 0x40, 0x40, 0x41 with dir = 1.
  - With COUNTER_CHECKER_STALL_EN: no err.
  - Without: err pulse on the repeated 0x40, err_cnt = 1.
